// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode channel bundle for the IF/ID instruction queue.
// master = fetch/decode side, slave = the queue itself.
interface if_id_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              flush;
  logic              stall;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [6:0]        out_opcode;
  logic [CNT_W-1:0]  count;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, stall,
    input  in_ready, out_valid, out_instr, out_pc, out_opcode, count, drop_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, stall,
    output in_ready, out_valid, out_instr, out_pc, out_opcode, count, drop_count
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID instruction queue: buffers fetched {instr, pc} pairs for decode,
// presents a NOP when empty and discards everything on a branch flush.
module if_id_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'hC800_0000,
  parameter int unsigned DROP_W    = 8
) (
  input logic            clk,
  input logic            rst,
  if_id_buffer_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [SUM_W-1:0]  drop_sum;
  logic              ready;
  logic              valid;
  logic              push;
  logic              pop;
  logic [31:0]       head_instr;
  logic [31:0]       head_pc;

  // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign ready    = !rst && (cnt_q < CNT_W'(DEPTH));
  assign valid    = (cnt_q != '0);
  assign push     = bus.in_valid && ready && !bus.flush;
  assign pop      = valid && !bus.stall && !bus.flush;
  assign drop_sum = SUM_W'(drop_q) + SUM_W'(cnt_q) + SUM_W'(bus.in_valid);

  // Next-state: flush wins over push/pop and accounts for the incoming word too.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (bus.flush) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      drop_d = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : DROP_W'(drop_sum);
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= entry_t'{instr: bus.in_instr, pc: bus.in_pc};
    end
  end

  assign head_instr = valid ? mem[rd_q].instr : NOP_INSTR;
  assign head_pc    = valid ? mem[rd_q].pc    : 32'h0;

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid;
  assign bus.out_instr  = head_instr;
  assign bus.out_pc     = head_pc;
  assign bus.out_opcode = head_instr[31:25];
  assign bus.count      = cnt_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed + randomized bench for if_id_buffer against a queue-based model.
module tb_if_id_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DROP_W = 3;
  localparam int          DMAX   = (1 << DROP_W) - 1;
  localparam logic [31:0] NOP    = 32'hC800_0000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t q[$];
  int   drop = 0;

  if_id_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .DROP_W(DROP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] ei, ep;
    if (q.size() != 0) begin
      ei = q[0].instr;
      ep = q[0].pc;
    end else begin
      ei = NOP;
      ep = 32'h0;
    end
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    chk({tag, ".instr"}, bus.out_instr, ei);
    chk({tag, ".pc"}, bus.out_pc, ep);
    chk({tag, ".opcode"}, 32'(bus.out_opcode), 32'(ei[31:25]));
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".ready"}, 32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk({tag, ".drop"}, 32'(bus.drop_count), 32'(drop));
  endtask

  // Apply one cycle of inputs, check the pre-edge view, advance model and clock.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] p, input logic fl, input logic st);
    logic do_push, do_pop;
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = p;
    bus.flush    = fl;
    bus.stall    = st;
    check_state(tag);
    do_push = v && (q.size() < DEPTH) && !fl;
    do_pop  = (q.size() != 0) && !st && !fl;
    if (fl) begin
      drop = drop + q.size() + int'(v);
      if (drop > DMAX) drop = DMAX;
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{ins, p});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_pc    = 32'h0;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst.ready_low", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    drop = 0;
    #1;
    check_state("reset");
    chk("reset.nop", bus.out_instr, 32'hC800_0000);
    chk("reset.opcode", 32'(bus.out_opcode), 32'h64);
    chk("reset.ready", 32'(bus.in_ready), 32'h1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.in_pc    = 32'h0;
    bus.flush    = 1'b0;
    bus.stall    = 1'b0;
    @(negedge clk);
    do_reset();

    // Single pass-through
    step("pt.push", 1'b1, 32'h1234_5678, 32'h10, 1'b0, 1'b0);
    chk("pt.out_instr", bus.out_instr, 32'h1234_5678);
    chk("pt.out_pc", bus.out_pc, 32'h10);
    chk("pt.out_valid", 32'(bus.out_valid), 32'h1);
    step("pt.pop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pt.count0", 32'(bus.count), 32'h0);
    chk("pt.nop", bus.out_instr, 32'hC800_0000);

    // Fill under stall, overflow attempt, then drain across the wrap
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i), 1'b0, 1'b1);
    chk("fill.count4", 32'(bus.count), 32'h4);
    chk("fill.ready0", 32'(bus.in_ready), 32'h0);
    chk("fill.head_stable", bus.out_pc, 32'h0);
    step("fill.over", 1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b1);
    chk("fill.over_count", 32'(bus.count), 32'h4);
    step("drain.pop0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("drain.push10", 1'b1, 32'hA000_0010, 32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drain.empty", 32'(bus.count), 32'h0);

    // Simultaneous push/pop at steady occupancy 2
    do_reset();
    step("pp.fill0", 1'b1, 32'hB000_0000, 32'h100, 1'b0, 1'b1);
    step("pp.fill1", 1'b1, 32'hB000_0001, 32'h104, 1'b0, 1'b1);
    for (int i = 2; i < 7; i++) step("pp", 1'b1, 32'hB000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    chk("pp.count2", 32'(bus.count), 32'h2);
    chk("pp.head", bus.out_pc, 32'h114);

    // Flush priority with an incoming instruction
    do_reset();
    for (int i = 0; i < 3; i++) step("fl.fill", 1'b1, 32'hC000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b1);
    step("fl.flush", 1'b1, 32'hBAD0_BAD0, 32'h2FC, 1'b1, 1'b0);
    chk("fl.count0", 32'(bus.count), 32'h0);
    chk("fl.valid0", 32'(bus.out_valid), 32'h0);
    chk("fl.drop4", 32'(bus.drop_count), 32'h4);
    step("fl.idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("fl.empty_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fl.drop_keep", 32'(bus.drop_count), 32'h4);

    // drop_count saturation
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step("sat.fill", 1'b1, 32'($urandom), 32'($urandom), 1'b0, 1'b1);
      step("sat.flush", 1'b1, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
      chk("sat.drop", 32'(bus.drop_count), (r == 0) ? 32'h5 : 32'h7);
    end

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 32'($urandom), 32'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));
    end
    step("rnd.final", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
